// File: rtl/transform_iq_pkg.sv
// Shared encodings for the transform_iq inverse-quantiser: block types, FSM states
// and the LevelScale table indexed by QP%6 and coefficient position class.
package transform_iq_pkg;

  localparam logic [2:0] BT_LUMA_DC   = 3'd1;
  localparam logic [2:0] BT_LUMA_AC   = 3'd2;
  localparam logic [2:0] BT_LUMA_4X4  = 3'd3;
  localparam logic [2:0] BT_CHROMA_DC = 3'd5;
  localparam logic [2:0] BT_CHROMA_AC = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_QPDIV = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } iq_state_e;

  // Position class: 0 = both even, 1 = mixed parity, 2 = both odd.
  localparam logic [1:0] LS_SEL_V0 = 2'd0;
  localparam logic [1:0] LS_SEL_V1 = 2'd1;
  localparam logic [1:0] LS_SEL_V2 = 2'd2;

  function automatic logic [4:0] level_scale(input logic [5:0] rem, input logic [1:0] sel);
    logic [14:0] row;
    case (rem)
      6'd0:    row = {5'd16, 5'd13, 5'd10};
      6'd1:    row = {5'd18, 5'd14, 5'd11};
      6'd2:    row = {5'd20, 5'd16, 5'd13};
      6'd3:    row = {5'd23, 5'd18, 5'd14};
      6'd4:    row = {5'd25, 5'd20, 5'd16};
      default: row = {5'd29, 5'd23, 5'd18};
    endcase
    case (sel)
      LS_SEL_V0: return row[4:0];
      LS_SEL_V1: return row[9:5];
      default:   return row[14:10];
    endcase
  endfunction

  function automatic logic bt_supported(input logic [2:0] bt);
    return (bt == BT_LUMA_DC) || (bt == BT_LUMA_AC) || (bt == BT_LUMA_4X4) ||
           (bt == BT_CHROMA_DC) || (bt == BT_CHROMA_AC);
  endfunction

endpackage

// File: rtl/transform_iq_qpdiv6.sv
// Iterative QP divide-by-6: one subtract step per enabled cycle while step is high.
// Latency: qp/6 steps after start; busy is high while another step remains.
// Backpressure: none; holds when ena is low, start restarts from qp.
module transform_iq_qpdiv6 (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       start,
  input  logic       step,
  input  logic [5:0] qp,
  output logic       busy,
  output logic [3:0] qp_div,
  output logic [5:0] qp_rem
);

  assign busy = (qp_rem >= 6'd6);

  always_ff @(posedge clk) begin
    if (rst) begin
      qp_div <= '0;
      qp_rem <= '0;
    end else if (ena) begin
      if (start) begin
        qp_div <= '0;
        qp_rem <= qp;
      end else if (step && busy) begin
        qp_div <= qp_div + 4'd1;
        qp_rem <= qp_rem - 6'd6;
      end
    end
  end

endmodule

// File: rtl/transform_iq.sv
// Inverse quantiser for one 4x4 (or packed 2x2 chroma DC) block, row per handshake; TRANSFORM_IQ_SAT_EN clamps outputs.
// Latency: row accepted in cycle N appears on out_row in cycle N+2; done rides the last row.
// Backpressure: in_ready only in RUN; no output backpressure, ena low freezes everything.
module transform_iq
  import transform_iq_pkg::*;
#(
  parameter int COEFF_W = 16,
  parameter int OUT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               start,
  input  logic [2:0]         block_type,
  input  logic [5:0]         qp,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*COEFF_W-1:0] in_row,
  output logic               out_valid,
  output logic [4*OUT_W-1:0] out_row,
  output logic [1:0]         out_row_idx,
  output logic               done
);

  localparam int PW = COEFF_W + 5;
  localparam int WW = PW + 16;

  iq_state_e state, state_nx;
  logic [2:0] lat_type;
  logic [5:0] lat_qp;
  logic [1:0] r;

  logic       div_busy;
  logic [3:0] qp_div;
  logic [5:0] qp_rem;

  logic                      s1_v, s1_last;
  logic [1:0]                s1_idx;
  logic signed [COEFF_W-1:0] s1_c0;
  logic signed [PW-1:0]      s1_prod [4];
  logic signed [PW-1:0]      prod [4];
  logic [4*OUT_W-1:0]        out_nx;

  logic supported, accept, last_row;

  assign supported = bt_supported(block_type);
  assign in_ready  = (state == S_RUN);
  assign accept    = in_valid && in_ready && !start;
  assign last_row  = (lat_type == BT_CHROMA_DC) || (r == 2'd3);

  transform_iq_qpdiv6 u_qpdiv6 (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .start  (start),
    .step   (state == S_QPDIV),
    .qp     (qp),
    .busy   (div_busy),
    .qp_div (qp_div),
    .qp_rem (qp_rem)
  );

  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = supported ? S_QPDIV : S_FLUSH;
    end else begin
      case (state)
        S_QPDIV: if (!div_busy) state_nx = S_RUN;
        S_RUN:   if (accept && last_row) state_nx = S_FLUSH;
        S_FLUSH: if (!s1_v && !s1_last) state_nx = S_IDLE;
        default: state_nx = state;
      endcase
    end
  end

  function automatic logic [1:0] ls_sel(input logic [1:0] i, input int j, input logic dc2x2);
    if (dc2x2) return LS_SEL_V0;
    if (!i[0] && !j[0]) return LS_SEL_V0;
    if (i[0] && j[0]) return LS_SEL_V2;
    return LS_SEL_V1;
  endfunction

  // Stage 1: coefficient times LevelScale, full precision.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      prod[j] = PW'($signed(in_row[j*COEFF_W +: COEFF_W])) *
                PW'($signed({1'b0, level_scale(qp_rem, ls_sel(r, j, lat_type == BT_CHROMA_DC))}));
    end
  end

  function automatic logic [OUT_W-1:0] stage2(input logic signed [PW-1:0] p,
                                              input logic signed [COEFF_W-1:0] c,
                                              input logic dc_pos, input logic [2:0] bt,
                                              input logic qp_ge12, input logic [3:0] qd);
    logic signed [WW-1:0] pe;
    logic signed [WW-1:0] w;
`ifdef TRANSFORM_IQ_SAT_EN
    logic signed [WW-1:0] omax;
    logic signed [WW-1:0] omin;
`endif
    pe = WW'(p);
    if ((bt == BT_LUMA_AC || bt == BT_CHROMA_AC) && dc_pos) begin
      w = WW'(c);  // AC-block DC term is already scaled by the DC path
    end else if (bt == BT_LUMA_DC) begin
      if (qp_ge12) w = pe <<< (qd - 4'd2);
      else         w = (pe + (WW'(1) <<< (4'd1 - qd))) >>> (4'd2 - qd);
    end else if (bt == BT_CHROMA_DC) begin
      w = (pe <<< qd) >>> 1;
    end else begin
      w = pe <<< qd;
    end
`ifdef TRANSFORM_IQ_SAT_EN
    omax = (WW'(1) <<< (OUT_W - 1)) - WW'(1);
    omin = -(WW'(1) <<< (OUT_W - 1));
    if (w > omax)      w = omax;
    else if (w < omin) w = omin;
`endif
    return w[OUT_W-1:0];
  endfunction

  // Stage 2: per-type shift/round, then clamp or wrap to OUT_W.
  always_comb begin
    out_nx = '0;
    for (int j = 0; j < 4; j++) begin
      out_nx[j*OUT_W +: OUT_W] = stage2(s1_prod[j], s1_c0, (s1_idx == 2'd0) && (j == 0),
                                        lat_type, lat_qp >= 6'd12, qp_div);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      lat_type    <= '0;
      lat_qp      <= '0;
      r           <= '0;
      s1_v        <= 1'b0;
      s1_last     <= 1'b0;
      s1_idx      <= '0;
      s1_c0       <= '0;
      for (int j = 0; j < 4; j++) s1_prod[j] <= '0;
      out_valid   <= 1'b0;
      done        <= 1'b0;
      out_row     <= '0;
      out_row_idx <= '0;
    end else if (ena) begin
      state <= state_nx;
      if (start) begin
        // Abort anything in flight; an unsupported type still produces a bare done.
        lat_type  <= block_type;
        lat_qp    <= qp;
        r         <= '0;
        s1_v      <= 1'b0;
        s1_last   <= !supported;
        out_valid <= 1'b0;
        done      <= 1'b0;
      end else begin
        s1_v    <= accept;
        s1_last <= accept && last_row;
        if (accept) begin
          r      <= last_row ? 2'd0 : r + 2'd1;
          s1_idx <= r;
          s1_c0  <= $signed(in_row[COEFF_W-1:0]);
          for (int j = 0; j < 4; j++) s1_prod[j] <= prod[j];
        end
        out_valid <= s1_v;
        done      <= s1_last;
        if (s1_v) begin
          out_row     <= out_nx;
          out_row_idx <= s1_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_transform_iq.sv
// Table-driven bench for transform_iq: per-block vectors with hand-computed results,
// a scoreboard queue checked on every out_valid, plus abort, stall and no-op sequences.
module tb_transform_iq;

  localparam int RW = 64;

  logic          clk = 1'b0;
  logic          rst, ena, start, in_valid;
  logic [2:0]    block_type;
  logic [5:0]    qp;
  logic          in_ready, out_valid, done;
  logic [RW-1:0] in_row, out_row;
  logic [1:0]    out_row_idx;

  transform_iq #(.COEFF_W(16), .OUT_W(16)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .block_type(block_type), .qp(qp),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row), .out_valid(out_valid),
    .out_row(out_row), .out_row_idx(out_row_idx), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                   bt;
    int                   qp;
    int                   nrows;
    logic [3:0][RW-1:0]   rin;
    logic [3:0][RW-1:0]   rexp;
  } vec_t;

  typedef struct {
    logic [RW-1:0] row;
    logic [1:0]    idx;
    logic          last;
    int            due;
  } exp_t;

  vec_t tbl [8];
  exp_t sb [$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   allow_bare_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [RW-1:0] mkrow(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ena && out_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: out_valid=1 idx=%0d row=%h, required no output", out_row_idx, out_row);
      end else begin
        mon_e = sb.pop_front();
        chk("out_row", out_row, mon_e.row);
        chk("out_row_idx", RW'(out_row_idx), RW'(mon_e.idx));
        chk("done_with_row", RW'(done), RW'(mon_e.last));
        if (mon_e.due >= 0) chk("row_latency", RW'(cyc), RW'(mon_e.due));
      end
    end else if (!rst && ena && done && !allow_bare_done) begin
      n_vec++;
      n_err++;
      $display("FAIL spurious_done: done=1 without out_valid, required 0");
    end
  end

  task automatic run_block(input int k, input int nsend, input bit abort_after, input bit stall);
    vec_t v;
    int   lat;
    int   cnt;
    v          = tbl[k];
    start      = 1'b1;
    block_type = 3'(v.bt);
    qp         = 6'(v.qp);
    in_valid   = 1'b1;          // held early: must not be taken before in_ready
    in_row     = v.rin[0];
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!in_ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("qpdiv_latency", RW'(lat), RW'(v.qp / 6 + 1));
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    for (int i = 0; i < nsend; i++) begin
      in_row   = v.rin[i];
      in_valid = 1'b1;
      if (!abort_after || i < nsend - 1)
        sb.push_back('{v.rexp[i], 2'(i), (i == v.nrows - 1), (stall ? -1 : cyc + 2)});
      @(posedge clk); #1;
      if (stall && i == 1) begin
        in_valid = 1'b0;
        ena      = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        ena = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!abort_after) begin
      cnt = 0;
      while (sb.size() != 0 && cnt < 40) begin
        @(posedge clk); #1;
        cnt++;
      end
      chk("drain_pending", RW'(sb.size()), RW'(0));
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{3, 28, 4, '0, '0};
    tbl[0].rin[0] = mkrow(1, 0, 0, 0);   tbl[0].rexp[0] = mkrow(256, 0, 0, 0);
    tbl[0].rin[1] = mkrow(1, 0, 0, 0);   tbl[0].rexp[1] = mkrow(320, 0, 0, 0);
    tbl[0].rin[2] = mkrow(0, 2, 0, -1);  tbl[0].rexp[2] = mkrow(0, 640, 0, -320);
    tbl[0].rin[3] = mkrow(0, 1, 0, 3);   tbl[0].rexp[3] = mkrow(0, 400, 0, 1200);
    tbl[1] = '{1, 10, 4, '0, '0};
    tbl[1].rin[0] = mkrow(3, 0, 0, 0);   tbl[1].rexp[0] = mkrow(24, 0, 0, 0);
    tbl[1].rin[1] = mkrow(0, -3, 0, 0);  tbl[1].rexp[1] = mkrow(0, -37, 0, 0);
    tbl[1].rin[2] = mkrow(5, 0, 0, 0);   tbl[1].rexp[2] = mkrow(40, 0, 0, 0);
    tbl[1].rin[3] = mkrow(0, 0, 0, 1);   tbl[1].rexp[3] = mkrow(0, 0, 0, 13);
    tbl[2] = '{1, 30, 4, '0, '0};
    tbl[2].rin[0] = mkrow(3, 0, 0, 0);   tbl[2].rexp[0] = mkrow(240, 0, 0, 0);
    tbl[2].rin[1] = mkrow(0, 0, 0, 0);   tbl[2].rexp[1] = mkrow(0, 0, 0, 0);
    tbl[2].rin[2] = mkrow(0, 0, 1, 0);   tbl[2].rexp[2] = mkrow(0, 0, 80, 0);
    tbl[2].rin[3] = mkrow(0, -2, 0, 0);  tbl[2].rexp[3] = mkrow(0, -256, 0, 0);
    tbl[3] = '{5, 20, 1, '0, '0};
    tbl[3].rin[0] = mkrow(2, 0, 0, -1);  tbl[3].rexp[0] = mkrow(104, 0, 0, -52);
    tbl[4] = '{2, 28, 4, '0, '0};
    tbl[4].rin[0] = mkrow(77, 1, 0, 0);  tbl[4].rexp[0] = mkrow(77, 320, 0, 0);
    tbl[4].rin[1] = mkrow(2, 0, 0, 0);   tbl[4].rexp[1] = mkrow(640, 0, 0, 0);
    tbl[5] = '{6, 0, 4, '0, '0};
    tbl[5].rin[0] = mkrow(-5, 2, 0, 0);  tbl[5].rexp[0] = mkrow(-5, 26, 0, 0);
    tbl[5].rin[1] = mkrow(0, 1, 0, 0);   tbl[5].rexp[1] = mkrow(0, 16, 0, 0);
    tbl[5].rin[3] = mkrow(1, 0, 0, 0);   tbl[5].rexp[3] = mkrow(13, 0, 0, 0);
    tbl[6] = '{3, 51, 4, '0, '0};
    tbl[6].rin[0] = mkrow(1000, 0, 0, 0);
    tbl[6].rin[1] = mkrow(-1, 0, 0, 0);  tbl[6].rexp[1] = mkrow(-4608, 0, 0, 0);
    tbl[6].rin[2] = mkrow(-1000, 0, 0, 0);
`ifdef TRANSFORM_IQ_SAT_EN
    tbl[6].rexp[0] = mkrow(32767, 0, 0, 0);
    tbl[6].rexp[2] = mkrow(-32768, 0, 0, 0);
`else
    tbl[6].rexp[0] = mkrow(-20480, 0, 0, 0);
    tbl[6].rexp[2] = mkrow(20480, 0, 0, 0);
`endif
    tbl[7] = '{3, 0, 4, '0, '0};
    tbl[7].rin[0] = mkrow(1, 1, 1, 1);   tbl[7].rexp[0] = mkrow(10, 13, 10, 13);
    tbl[7].rin[1] = mkrow(1, 1, 1, 1);   tbl[7].rexp[1] = mkrow(13, 16, 13, 16);
    tbl[7].rin[2] = mkrow(1, 1, 1, 1);   tbl[7].rexp[2] = mkrow(10, 13, 10, 13);
    tbl[7].rin[3] = mkrow(1, 1, 1, 1);   tbl[7].rexp[3] = mkrow(13, 16, 13, 16);

    rst = 1'b1; ena = 1'b1; start = 1'b0; in_valid = 1'b0;
    block_type = 3'd0; qp = 6'd0; in_row = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", RW'(in_ready), RW'(0));
    chk("reset_out_valid", RW'(out_valid), RW'(0));
    chk("reset_done", RW'(done), RW'(0));
    chk("reset_out_row", out_row, RW'(0));
    chk("reset_out_row_idx", RW'(out_row_idx), RW'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) run_block(k, tbl[k].nrows, 1'b0, 1'b0);

    // Abort after two accepted rows: only row 0 has left stage 2 before start lands.
    run_block(0, 2, 1'b1, 1'b0);
    run_block(4, 4, 1'b0, 1'b0);

    // ena low for three cycles in the middle of a block.
    run_block(7, 4, 1'b0, 1'b1);

    // Unsupported type: no rows, bare done two cycles after start.
    allow_bare_done = 1'b1;
    start = 1'b1; block_type = 3'd7; qp = 6'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("nop_done_c1", RW'(done), RW'(0));
    @(negedge clk);
    chk("nop_done_c2", RW'({done, out_valid}), RW'(2'b10));
    @(negedge clk);
    chk("nop_done_c3", RW'(done), RW'(0));
    allow_bare_done = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_in_ready", RW'(in_ready), RW'(0));
    chk("leftover_expect", RW'(sb.size()), RW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
